// File: rtl/serv_rf_ram_arbiter_pkg.sv
// serv_rf_ram_arbiter_pkg: shared types and default geometry for the RF-RAM arbiter.
//   state_t      - arbiter FSM states
//   RAW/AW/DEPTH - register-address width, SRAM address width and SRAM depth
//                  at the default configuration (width=8, csr_regs=4)
package serv_rf_ram_arbiter_pkg;

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_CORE,
        S_DBG_RD,
        S_DBG_DONE
    } state_t;

    localparam int RAW   = $clog2(32 + 4);
    localparam int AW    = 5 + RAW - $clog2(8);
    localparam int DEPTH = 1 << AW;

endpackage

// File: rtl/serv_rf_ram_arbiter.sv
// serv_rf_ram_arbiter: owns the register-file SRAM and grants it to the clear
// sequencer, the SERV core (via the RF-RAM interface) or a debug peek/poke port.
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_core_rreq/i_core_wreq        core request pulses, latched until forwarded
//   o_rfif_rreq/o_rfif_wreq        requests forwarded to the RF-RAM interface
//   i_rfif_* / o_rfif_rdata        interface SRAM traffic, passed through in CORE
//   i_dbg_* / o_dbg_ack/o_dbg_rdata debug word access, ack pulse on completion
//   o_waddr..o_ren, i_rdata        SRAM ports
//   o_init_done                    high once the SRAM has been zeroed
module serv_rf_ram_arbiter
    import serv_rf_ram_arbiter_pkg::*;
#(
    parameter int width      = 8,
    parameter int csr_regs   = 4,
    parameter int txn_cycles = 36,
    parameter bit clear_en   = 1'b1,
    parameter int raw        = $clog2(32 + csr_regs),
    parameter int aw         = 5 + raw - $clog2(width)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_core_rreq,
    input  logic             i_core_wreq,
    output logic             o_rfif_rreq,
    output logic             o_rfif_wreq,
    input  logic [aw-1:0]    i_rfif_waddr,
    input  logic [width-1:0] i_rfif_wdata,
    input  logic             i_rfif_wen,
    input  logic [aw-1:0]    i_rfif_raddr,
    input  logic             i_rfif_ren,
    output logic [width-1:0] o_rfif_rdata,
    input  logic             i_dbg_req,
    input  logic             i_dbg_we,
    input  logic [aw-1:0]    i_dbg_addr,
    input  logic [width-1:0] i_dbg_wdata,
    output logic             o_dbg_ack,
    output logic [width-1:0] o_dbg_rdata,
    output logic [aw-1:0]    o_waddr,
    output logic [width-1:0] o_wdata,
    output logic             o_wen,
    output logic [aw-1:0]    o_raddr,
    output logic             o_ren,
    input  logic [width-1:0] i_rdata,
    output logic             o_init_done
);

    localparam int ww = (txn_cycles > 1) ? $clog2(txn_cycles) : 1;
    localparam logic [ww-1:0] win_load = ww'(txn_cycles - 1);

    state_t           state_q, state_d;
    logic [aw:0]      clr_cnt_q, clr_cnt_d;
    logic [ww-1:0]    win_q, win_d;
    logic             pend_r_q, pend_r_d, pend_w_q, pend_w_d;
    logic [width-1:0] dbg_rdata_q, dbg_rdata_d;
    logic             core_any, fwd;

    // Incoming pulses count as pending in the same cycle so forwarding adds no latency.
    assign core_any = pend_r_q | pend_w_q | i_core_rreq | i_core_wreq;
    assign fwd      = (state_q == S_IDLE) & core_any;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= clear_en ? S_CLEAR : S_IDLE;
            clr_cnt_q   <= '0;
            win_q       <= '0;
            pend_r_q    <= 1'b0;
            pend_w_q    <= 1'b0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            win_q       <= win_d;
            pend_r_q    <= pend_r_d;
            pend_w_q    <= pend_w_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        win_d       = win_q;
        dbg_rdata_d = dbg_rdata_q;
        pend_r_d    = (pend_r_q | i_core_rreq) & ~fwd;
        pend_w_d    = (pend_w_q | i_core_wreq) & ~fwd;
        case (state_q)
            S_CLEAR: begin
                // Counter MSB becomes the done flag on the edge after the last address.
                clr_cnt_d = clr_cnt_q + 1'b1;
                state_d   = (&clr_cnt_q[aw-1:0]) ? S_IDLE : S_CLEAR;
            end
            S_IDLE: begin
                if (core_any) begin
                    win_d   = win_load;
                    state_d = S_CORE;
                end else if (i_dbg_req) begin
                    state_d = i_dbg_we ? S_DBG_DONE : S_DBG_RD;
                end
            end
            S_CORE: begin
                win_d   = (win_q == '0) ? win_q : win_q - 1'b1;
                state_d = (win_q == '0) ? S_IDLE : S_CORE;
            end
            S_DBG_RD: begin
                dbg_rdata_d = i_rdata;
                state_d     = S_DBG_DONE;
            end
            S_DBG_DONE: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // SRAM port mux; everything is forced idle while reset is asserted.
    always_comb begin
        o_rfif_rreq  = 1'b0;
        o_rfif_wreq  = 1'b0;
        o_rfif_rdata = '0;
        o_dbg_ack    = 1'b0;
        o_waddr      = '0;
        o_wdata      = '0;
        o_wen        = 1'b0;
        o_raddr      = '0;
        o_ren        = 1'b0;
        if (i_rst_n) begin
            case (state_q)
                S_CLEAR: begin
                    o_wen   = 1'b1;
                    o_waddr = clr_cnt_q[aw-1:0];
                end
                S_IDLE: begin
                    if (core_any) begin
                        o_rfif_rreq = pend_r_q | i_core_rreq;
                        o_rfif_wreq = pend_w_q | i_core_wreq;
                    end else if (i_dbg_req & i_dbg_we) begin
                        o_wen   = 1'b1;
                        o_waddr = i_dbg_addr;
                        o_wdata = i_dbg_wdata;
                    end else if (i_dbg_req) begin
                        o_ren   = 1'b1;
                        o_raddr = i_dbg_addr;
                    end
                end
                S_CORE: begin
                    o_waddr      = i_rfif_waddr;
                    o_wdata      = i_rfif_wdata;
                    o_wen        = i_rfif_wen;
                    o_raddr      = i_rfif_raddr;
                    o_ren        = i_rfif_ren;
                    o_rfif_rdata = i_rdata;
                end
                S_DBG_DONE: o_dbg_ack = 1'b1;
                default: ;
            endcase
        end
    end

    assign o_dbg_rdata = dbg_rdata_q;
    assign o_init_done = clr_cnt_q[aw] | ~clear_en;

endmodule

// File: tb/tb_serv_rf_ram_arbiter.sv
// tb_serv_rf_ram_arbiter: directed self-checking bench for serv_rf_ram_arbiter.
module tb_serv_rf_ram_arbiter;
    import serv_rf_ram_arbiter_pkg::*;

    logic            i_clk = 1'b0;
    logic            i_rst_n;
    logic            i_core_rreq, i_core_wreq;
    logic            o_rfif_rreq, o_rfif_wreq;
    logic [AW-1:0]   i_rfif_waddr, i_rfif_raddr;
    logic [7:0]      i_rfif_wdata;
    logic            i_rfif_wen, i_rfif_ren;
    logic [7:0]      o_rfif_rdata;
    logic            i_dbg_req, i_dbg_we;
    logic [AW-1:0]   i_dbg_addr;
    logic [7:0]      i_dbg_wdata;
    logic            o_dbg_ack;
    logic [7:0]      o_dbg_rdata;
    logic [AW-1:0]   o_waddr, o_raddr;
    logic [7:0]      o_wdata;
    logic            o_wen, o_ren;
    logic [7:0]      i_rdata = 8'h00;
    logic            o_init_done;

    logic [7:0]      mem [DEPTH];
    int              checks = 0;
    int              errors = 0;

    serv_rf_ram_arbiter dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_core_rreq(i_core_rreq), .i_core_wreq(i_core_wreq),
        .o_rfif_rreq(o_rfif_rreq), .o_rfif_wreq(o_rfif_wreq),
        .i_rfif_waddr(i_rfif_waddr), .i_rfif_wdata(i_rfif_wdata), .i_rfif_wen(i_rfif_wen),
        .i_rfif_raddr(i_rfif_raddr), .i_rfif_ren(i_rfif_ren), .o_rfif_rdata(o_rfif_rdata),
        .i_dbg_req(i_dbg_req), .i_dbg_we(i_dbg_we), .i_dbg_addr(i_dbg_addr),
        .i_dbg_wdata(i_dbg_wdata), .o_dbg_ack(o_dbg_ack), .o_dbg_rdata(o_dbg_rdata),
        .o_waddr(o_waddr), .o_wdata(o_wdata), .o_wen(o_wen),
        .o_raddr(o_raddr), .o_ren(o_ren), .i_rdata(i_rdata),
        .o_init_done(o_init_done)
    );

    always #5 i_clk = ~i_clk;

    // SRAM model: synchronous write, one-cycle read latency.
    always @(posedge i_clk) begin
        if (o_wen) mem[o_waddr] <= o_wdata;
        if (o_ren) i_rdata <= mem[o_raddr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_rst_n = 1'b0; i_core_rreq = 1'b0; i_core_wreq = 1'b0;
        i_rfif_waddr = '0; i_rfif_raddr = '0; i_rfif_wdata = '0;
        i_rfif_wen = 1'b0; i_rfif_ren = 1'b0;
        i_dbg_req = 1'b0; i_dbg_we = 1'b0; i_dbg_addr = '0; i_dbg_wdata = '0;
        #3;
        chk("reset_outputs", {o_wen, o_ren, o_dbg_ack, o_rfif_rreq, o_rfif_wreq, o_init_done, o_dbg_rdata}, 0);
        tick();
        tick();
        i_rst_n = 1'b1;

        // Clear: 256 cycles of zero writes; core read pulse in cycle 10 is held back.
        for (int i = 0; i < DEPTH; i++) begin
            i_core_rreq = (i == 9);
            #1;
            chk("clear_cycle", {o_wen, o_waddr, o_wdata, o_init_done, o_rfif_rreq}, {1'b1, 8'(i), 8'h00, 1'b0, 1'b0});
            tick();
        end
        i_core_rreq = 1'b0;
        #1;
        chk("first_idle_fwd", {o_init_done, o_rfif_rreq, o_rfif_wreq, o_wen}, 4'b1100);
        tick();

        // CORE window: SRAM driven from the interface for exactly 36 cycles.
        for (int j = 0; j < 36; j++) begin
            i_rfif_waddr = 8'(j + 3);
            i_rfif_wdata = 8'(j) ^ 8'h5A;
            i_rfif_wen   = j[0];
            i_rfif_raddr = 8'(j + 1);
            i_rfif_ren   = 1'b1;
            #1;
            chk("core_pass", {o_waddr, o_wdata, o_wen, o_raddr, o_ren, o_rfif_rreq},
                {8'(j + 3), 8'(j) ^ 8'h5A, j[0], 8'(j + 1), 1'b1, 1'b0});
            chk("core_rdata", {24'h0, o_rfif_rdata}, {24'h0, i_rdata});
            tick();
        end
        #1;
        chk("core_end_rdata_nonzero", {24'h0, i_rdata}, 32'h7B);
        chk("core_end_owner", {o_wen, o_ren, o_rfif_rdata}, 10'h000);
        i_rfif_wen = 1'b0; i_rfif_ren = 1'b0;

        // Debug write 0x12 <= 0xA5, ack one cycle after accept.
        i_dbg_req = 1'b1; i_dbg_we = 1'b1; i_dbg_addr = 8'h12; i_dbg_wdata = 8'hA5;
        #1;
        chk("dbg_wr_accept", {o_wen, o_waddr, o_wdata, o_dbg_ack}, {1'b1, 8'h12, 8'hA5, 1'b0});
        tick();
        chk("dbg_wr_ack", {o_dbg_ack, o_wen}, 2'b10);
        i_dbg_req = 1'b0;
        tick();
        chk("dbg_wr_ack_gone", {o_dbg_ack, o_wen, o_ren}, 3'b000);

        // Debug read 0x12, ack two cycles after accept with the written data.
        i_dbg_req = 1'b1; i_dbg_we = 1'b0; i_dbg_addr = 8'h12;
        #1;
        chk("dbg_rd_accept", {o_ren, o_raddr, o_dbg_ack}, {1'b1, 8'h12, 1'b0});
        tick();
        chk("dbg_rd_wait", {o_dbg_ack, o_ren}, 2'b00);
        tick();
        chk("dbg_rd_ack", {o_dbg_ack, o_dbg_rdata}, {1'b1, 8'hA5});
        i_dbg_req = 1'b0;
        tick();

        // Debug read and core write arrive together: core wins, debug waits out the window.
        i_dbg_req = 1'b1; i_dbg_we = 1'b0; i_dbg_addr = 8'h06; i_core_wreq = 1'b1;
        #1;
        chk("arb_core_first", {o_rfif_wreq, o_rfif_rreq, o_ren}, 3'b100);
        tick();
        i_core_wreq = 1'b0;
        for (int j = 0; j < 36; j++) begin
            #1;
            chk("arb_no_dbg_in_core", {o_ren, o_dbg_ack, o_rfif_wreq}, 3'b000);
            tick();
        end
        #1;
        chk("arb_dbg_after_core", {o_ren, o_raddr, o_rfif_rreq, o_rfif_wreq}, {1'b1, 8'h06, 2'b00});
        tick();
        tick();
        chk("arb_dbg_ack", {o_dbg_ack, o_dbg_rdata}, {1'b1, 8'h59});
        i_dbg_req = 1'b0;
        tick();

        // Requests during CORE merge into pending bits, forwarded as one pulse.
        i_core_rreq = 1'b1;
        #1;
        chk("pend_first_fwd", {o_rfif_rreq, o_rfif_wreq}, 2'b10);
        tick();
        i_core_rreq = 1'b0;
        for (int j = 0; j < 36; j++) begin
            i_core_rreq = (j == 3) || (j == 20);
            i_core_wreq = (j == 7);
            #1;
            chk("pend_held", {o_rfif_rreq, o_rfif_wreq}, 2'b00);
            tick();
        end
        i_core_rreq = 1'b0; i_core_wreq = 1'b0;
        #1;
        chk("pend_fwd_both", {o_rfif_rreq, o_rfif_wreq}, 2'b11);
        tick();
        chk("pend_cleared", {o_rfif_rreq, o_rfif_wreq}, 2'b00);
        for (int j = 0; j < 36; j++) tick();
        chk("pend_no_refwd", {o_rfif_rreq, o_rfif_wreq}, 2'b00);

        // Reset during DBG_RD: outputs drop at once and no ack follows.
        i_dbg_req = 1'b1; i_dbg_we = 1'b0; i_dbg_addr = 8'h12;
        tick();
        i_rst_n = 1'b0;
        #1;
        chk("rst_dbg_rd", {o_ren, o_wen, o_dbg_ack, o_rfif_rreq, o_rfif_wreq, o_init_done, o_dbg_rdata}, 0);
        tick();
        chk("rst_dbg_no_ack", {o_dbg_ack, o_wen}, 2'b00);
        i_dbg_req = 1'b0;
        i_rst_n = 1'b1;

        // Reset at clear address 100, then a full clear from address 0.
        for (int i = 0; i <= 100; i++) begin
            #1;
            chk("clear2_cycle", {o_wen, o_waddr, o_init_done}, {1'b1, 8'(i), 1'b0});
            tick();
            if (i == 99) begin
                #1;
                chk("clear2_at_100", {o_wen, o_waddr}, {1'b1, 8'd100});
                i_rst_n = 1'b0;
                #1;
                chk("clear2_rst", {o_wen, o_waddr, o_init_done, o_dbg_ack}, 0);
                tick();
                i_rst_n = 1'b1;
                break;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            chk("clear3_cycle", {o_wen, o_waddr, o_wdata, o_init_done}, {1'b1, 8'(i), 8'h00, 1'b0});
            tick();
        end
        #1;
        chk("clear3_done", {o_init_done, o_wen, o_dbg_ack}, 3'b100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
